// File: rtl/display_scheduler_if.sv
// Bundle between the SECDED decoder/segment encoders and the display scheduler.
interface display_scheduler_if;
  logic       dato_valido;
  logic [6:0] siete_seg;
  logic [6:0] error;
  logic       swi;
  logic       error_simple;
  logic       error_doble;
  logic       no_error;
  logic [6:0] seg;
  logic [1:0] anodo;
  logic [1:0] modo;
  logic       led_error;

  modport master (
    output dato_valido, siete_seg, error, swi, error_simple, error_doble, no_error,
    input  seg, anodo, modo, led_error
  );

  modport slave (
    input  dato_valido, siete_seg, error, swi, error_simple, error_doble, no_error,
    output seg, anodo, modo, led_error
  );
endinterface

// File: rtl/display_scheduler.sv
// Two-digit seven-segment scheduler for the SECDED decoder: captures results on a
// strobe, picks a display mode by error priority, scans both digits, debounces the
// user switch and blinks the display on a double error.
module display_scheduler #(
  parameter int unsigned REFRESH_CYCLES  = 50000,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned BLINK_CYCLES    = 12500000
) (
  input logic                clk,
  input logic                rst,
  display_scheduler_if.slave bus
);

  localparam int unsigned SCAN_W  = (REFRESH_CYCLES  > 1) ? $clog2(REFRESH_CYCLES)  : 1;
  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BLINK_W = (BLINK_CYCLES    > 1) ? $clog2(BLINK_CYCLES)    : 1;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    INICIO = 2'b00,
    DATO   = 2'b01,
    SWITCH = 2'b10,
    ALERTA = 2'b11
  } state_t;

  state_t             state;
  state_t             next_state;

  logic [6:0]         cap_seg;
  logic [6:0]         cap_err;
  logic               cap_simple;
  logic               cap_doble;
  logic               cap_none;
  logic               cap_seen;

  logic               swi_meta;
  logic               swi_sync;
  logic               swi_db;
  logic [DB_W-1:0]    db_cnt;

  logic [SCAN_W-1:0]  scan_cnt;
  logic               digit_sel;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_off;

  logic [6:0]         seg_c;
  logic [1:0]         anodo_c;
  logic [6:0]         seg_q;
  logic [1:0]         anodo_q;
  logic               led_q;

  // Latch decoder results and flags on the strobe; remember that one arrived.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_seg    <= '0;
      cap_err    <= '0;
      cap_simple <= 1'b0;
      cap_doble  <= 1'b0;
      cap_none   <= 1'b0;
      cap_seen   <= 1'b0;
    end else if (bus.dato_valido) begin
      cap_seg    <= bus.siete_seg;
      cap_err    <= bus.error;
      cap_simple <= bus.error_simple;
      cap_doble  <= bus.error_doble;
      cap_none   <= bus.no_error;
      cap_seen   <= 1'b1;
    end
  end

  // Synchronize the raw switch, then accept a new level only after it stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swi_meta <= 1'b0;
      swi_sync <= 1'b0;
      swi_db   <= 1'b0;
      db_cnt   <= '0;
    end else begin
      swi_meta <= bus.swi;
      swi_sync <= swi_meta;
      if (swi_sync == swi_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        swi_db <= swi_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Digit scan: each digit holds for REFRESH_CYCLES, digit 0 first after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_sel <= 1'b0;
    end else if (scan_cnt == SCAN_W'(REFRESH_CYCLES - 1)) begin
      scan_cnt  <= '0;
      digit_sel <= ~digit_sel;
    end else begin
      scan_cnt  <= scan_cnt + SCAN_W'(1);
    end
  end

  // Blink phase timer; held cleared outside ALERTA so each alert starts in the on phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (state != ALERTA) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INICIO;
    end else begin
      state <= next_state;
    end
  end

  // Mode selection by captured-flag priority: double > single/none > invalid combination.
  always_comb begin
    next_state = INICIO;
    if (!cap_seen) begin
      next_state = INICIO;
    end else if (cap_doble) begin
      next_state = ALERTA;
    end else if (cap_simple || cap_none) begin
      next_state = DATO;
    end else begin
      next_state = SWITCH;
    end
  end

  // Segment/anode pattern for the current mode and digit slot.
  always_comb begin
    seg_c   = SEG_BLANK;
    anodo_c = 2'b11;
    case (state)
      DATO: begin
        if (!digit_sel) begin
          seg_c   = cap_seg;
          anodo_c = 2'b10;
        end else if (swi_db) begin
          seg_c   = cap_err;
          anodo_c = 2'b01;
        end
      end
      SWITCH: begin
        seg_c   = swi_db ? cap_err : cap_seg;
        anodo_c = digit_sel ? 2'b01 : 2'b10;
      end
      ALERTA: begin
        if (!blink_off) begin
          seg_c   = cap_err;
          anodo_c = digit_sel ? 2'b01 : 2'b10;
        end
      end
      default: begin
        seg_c   = SEG_BLANK;
        anodo_c = 2'b11;
      end
    endcase
  end

  // Register the pin outputs; reset blanks the display immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q   <= SEG_BLANK;
      anodo_q <= 2'b11;
      led_q   <= 1'b0;
    end else begin
      seg_q   <= seg_c;
      anodo_q <= anodo_c;
      led_q   <= cap_simple | cap_doble;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.anodo     = anodo_q;
  assign bus.modo      = state;
  assign bus.led_error = led_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with short refresh/debounce/blink periods.
module tb_display_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  display_scheduler_if bus ();

  display_scheduler #(
    .REFRESH_CYCLES (4),
    .DEBOUNCE_CYCLES(8),
    .BLINK_CYCLES   (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [6:0] s7, input logic [6:0] er,
                        input logic es, input logic ed, input logic ne);
    bus.siete_seg    = s7;
    bus.error        = er;
    bus.error_simple = es;
    bus.error_doble  = ed;
    bus.no_error     = ne;
    bus.dato_valido  = 1'b1;
    tick();
    bus.dato_valido  = 1'b0;
  endtask

  // 16 samples must split 8/8 between two slot patterns with a 4-cycle alternation.
  task automatic window(input string tag, input logic [6:0] sa, input logic [1:0] aa,
                        input logic [6:0] sb, input logic [1:0] ab);
    int ca;
    int cb;
    int per_bad;
    int cls [16];
    ca = 0;
    cb = 0;
    per_bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.seg === sa && bus.anodo === aa) begin
        cls[i] = 0;
        ca++;
      end else if (bus.seg === sb && bus.anodo === ab) begin
        cls[i] = 1;
        cb++;
      end else begin
        cls[i] = 2;
      end
    end
    for (int i = 0; i < 12; i++) begin
      if (cls[i] == 2 || cls[i] == cls[i+4]) per_bad++;
    end
    check({tag, "_slot_a"}, 32'(ca), 32'd8);
    check({tag, "_slot_b"}, 32'(cb), 32'd8);
    check({tag, "_period"}, 32'(per_bad), 32'd0);
  endtask

  initial begin
    int bad;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.dato_valido  = 1'b0;
    bus.siete_seg    = '0;
    bus.error        = '0;
    bus.swi          = 1'b0;
    bus.error_simple = 1'b0;
    bus.error_doble  = 1'b0;
    bus.no_error     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_seg",   32'(bus.seg),       32'h7F);
    check("rst_anodo", 32'(bus.anodo),     32'h3);
    check("rst_modo",  32'(bus.modo),      32'h0);
    check("rst_led",   32'(bus.led_error), 32'h0);
    rst = 1'b0;

    // No strobe: blank for 40 cycles in INICIO
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.seg !== 7'h7F || bus.anodo !== 2'b11 || bus.modo !== 2'b00) bad++;
    end
    check("inicio_blank", 32'(bad), 32'd0);

    // No-error result, switch low: digit 0 shows data, digit 1 blank
    strobe(7'h40, 7'h79, 1'b0, 1'b0, 1'b1);
    check("dato_modo_capture_cycle", 32'(bus.modo), 32'h0);
    tick();
    check("dato_modo", 32'(bus.modo),      32'h1);
    check("dato_led",  32'(bus.led_error), 32'h0);
    window("dato_swi0", 7'h40, 2'b10, 7'h7F, 2'b11);

    // 3-cycle high glitch must not change the debounced level
    bus.swi = 1'b1;
    repeat (3) tick();
    bus.swi = 1'b0;
    repeat (12) tick();
    window("dato_glitch_hi", 7'h40, 2'b10, 7'h7F, 2'b11);

    // Switch high long enough: digit 1 shows syndrome pattern
    bus.swi = 1'b1;
    repeat (12) tick();
    window("dato_swi1", 7'h40, 2'b10, 7'h79, 2'b01);

    // 3-cycle low glitch must not change the debounced level
    bus.swi = 1'b0;
    repeat (3) tick();
    bus.swi = 1'b1;
    repeat (12) tick();
    window("dato_glitch_lo", 7'h40, 2'b10, 7'h79, 2'b01);

    // Single error (with no_error also set) stays in DATO and lights the LED
    strobe(7'h40, 7'h79, 1'b1, 1'b0, 1'b1);
    check("simple_led_capture_cycle", 32'(bus.led_error), 32'h0);
    tick();
    check("simple_modo", 32'(bus.modo),      32'h1);
    check("simple_led",  32'(bus.led_error), 32'h1);

    // Double + single error: ALERTA, 16 on then 16 off
    strobe(7'h12, 7'h06, 1'b1, 1'b1, 1'b0);
    tick();
    check("alerta_modo", 32'(bus.modo),      32'h3);
    check("alerta_led",  32'(bus.led_error), 32'h1);
    window("alerta_on", 7'h06, 2'b10, 7'h06, 2'b01);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.seg !== 7'h7F || bus.anodo !== 2'b11) bad++;
    end
    check("alerta_off", 32'(bad), 32'd0);
    tick();
    check("alerta_on_again", 32'(bus.seg), 32'h06);

    // No flags: SWITCH mode, swi_db high shows captured error on both digits
    strobe(7'h24, 7'h30, 1'b0, 1'b0, 1'b0);
    check("switch_led_capture_cycle", 32'(bus.led_error), 32'h1);
    tick();
    check("switch_modo", 32'(bus.modo),      32'h2);
    check("switch_led",  32'(bus.led_error), 32'h0);
    window("switch_swi1", 7'h30, 2'b10, 7'h30, 2'b01);

    // Switch low in SWITCH mode: both digits show corrected word
    bus.swi = 1'b0;
    repeat (12) tick();
    window("switch_swi0", 7'h24, 2'b10, 7'h24, 2'b01);

    // Reset during ALERTA on phase blanks asynchronously
    strobe(7'h12, 7'h06, 1'b0, 1'b1, 1'b0);
    tick();
    check("alerta2_modo", 32'(bus.modo), 32'h3);
    repeat (4) tick();
    check("alerta2_on", 32'(bus.seg), 32'h06);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_seg",   32'(bus.seg),       32'h7F);
    check("async_rst_anodo", 32'(bus.anodo),     32'h3);
    check("async_rst_modo",  32'(bus.modo),      32'h0);
    check("async_rst_led",   32'(bus.led_error), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_modo", 32'(bus.modo), 32'h0);
    check("post_rst_seg",  32'(bus.seg),  32'h7F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Sequences the two-digit seven-segment display of the Hamming SECDED decoder.
- Captures the decoder outputs and the error flags when a strobe arrives.
- Time-multiplexes the corrected word (digit 0) and the syndrome/error pattern (digit 1) onto shared segment lines.
- Applies the display priority: double error > single error > no error > switch. Debounces the user switch and blinks the display on a double error.
- Sits between the decoder/seven-segment encoders and the board pins.

Parameters:
- REFRESH_CYCLES, 50000, clk cycles each digit stays lit per scan slot.
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required to accept a new swi level.
- BLINK_CYCLES, 12500000, length of each on phase and each off phase during double-error alert.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- dato_valido  in  1  one-cycle strobe: decoder outputs and flags are valid.
- siete_seg  in  7  segment pattern of the corrected word (active-low).
- error  in  7  segment pattern of the syndrome, or 'E' (active-low).
- swi  in  1  raw switch, asynchronous to clk.
- error_simple  in  1  single-error flag.
- error_doble  in  1  double-error flag.
- no_error  in  1  no-error flag.
- seg  out  7  segment lines, active-low.
- anodo  out  2  digit enables, active-low; bit0 = digit 0, bit1 = digit 1.
- modo  out  2  current state encoding (00 INICIO, 01 DATO, 10 SWITCH, 11 ALERTA).
- led_error  out  1  high while a single or double error is latched.

Behaviour:
- Reset (async, immediate):
  - seg = 7'b1111111, anodo = 2'b11, modo = 00, led_error = 0.
  - All counters = 0; swi_sync and swi_db = 0; captured registers = 0.
- Capture:
  - On a clk edge with dato_valido = 1, register siete_seg, error and the three flags.
  - Captured values hold until the next strobe.
- Switch path: 2-FF synchronizer, then debounce.
  - A counter increments while swi_sync != swi_db and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, swi_db takes the swi_sync value and the counter clears.
- State is evaluated each cycle from the captured flags, in priority order:
  - INICIO: no strobe received since reset.
  - ALERTA: error_doble captured.
  - DATO: error_simple or no_error captured.
  - SWITCH: no flag captured (invalid combination).
  - A new strobe can move between any of DATO, SWITCH and ALERTA on the cycle after capture. INICIO is never re-entered except through reset.
- Scan:
  - A scan counter counts 0..REFRESH_CYCLES-1 and wraps.
  - Digit select toggles on the wrap; digit 0 comes first after reset.
  - Counters run in every state.
- Outputs are registered from state, digit select and captured data (1-cycle latency):
  - INICIO: seg blank, anodo 11.
  - DATO: digit 0 slot → seg = captured siete_seg, anodo 10. Digit 1 slot → seg = captured error if swi_db = 1, otherwise blank with anodo 11.
  - SWITCH: both slots show the same pattern, digit 0 slot anodo 10, digit 1 slot anodo 01. The pattern is captured error if swi_db = 1, otherwise captured siete_seg.
  - ALERTA:
    - Both slots show captured error.
    - The blink counter runs only in ALERTA and clears on entry. The first phase is on; each phase lasts BLINK_CYCLES.
    - During the off phase: seg blank, anodo 11.
- led_error = captured error_simple OR captured error_doble, registered.
- Strobe in the same cycle as a scan wrap: both take effect; the next output uses the new data and the new digit.
- Multiple flags set: the priority above decides.
- Reset mid-scan or mid-blink: outputs blank immediately; operation restarts from digit 0 and INICIO.

Test Plan (REFRESH_CYCLES=4, DEBOUNCE_CYCLES=8, BLINK_CYCLES=16):
- Reset, no strobe, 40 cycles → seg = 7F and anodo = 11 throughout; modo = 00.
- Strobe with siete_seg=7'h40, error=7'h79, no_error=1, swi low → modo = 01. Digit 0 shows 40/anodo 10 for 4 cycles, then anodo 11 for 4 cycles, repeating; led_error = 0.
- Same data, swi high held 12 cycles → after sync plus 8 stable cycles, the digit 1 slot shows 79/anodo 01. A 3-cycle glitch on swi leaves swi_db unchanged.
- Strobe with error_doble=1, error_simple=1, error=7'h06 → modo = 11, led_error = 1. Scan shows 06 on both digits for 16 cycles, then blank with anodo 11 for 16 cycles.
- Strobe with all flags 0, swi_db = 1 → modo = 10; both digit slots show captured error.
- Assert rst during ALERTA on phase → seg = 7F and anodo = 11 in the same cycle (asynchronous); modo = 00 after release.
